// File: rtl/h264invdc_transform.sv
// Inverse 2x2 chroma DC Hadamard transform with serial in/out handshakes.
// Define H264INVDC_DEQUANT_EN to add the QP port and registered dequant scaling.
module h264invdc_transform #(
    parameter bit TOGETHER = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        READYI,
    input  logic        ENABLE,
    input  logic [15:0] XXIN,
`ifdef H264INVDC_DEQUANT_EN
    input  logic [5:0]  QP,
`endif
    output logic        VALID,
    output logic [15:0] YYOUT,
    input  logic        READYO
);

    typedef enum logic [1:0] {StLoad, StCalc, StScale, StOut} state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         ocnt_q, ocnt_d;
    logic               readyi_q, readyi_d;
    logic               valid_q, valid_d;
    logic [15:0]        yyout_q, yyout_d;
    logic signed [15:0] c_q [4];
    logic signed [15:0] c_d [4];
    logic signed [17:0] f_q [4];
    logic signed [17:0] f_d [4];
    logic signed [17:0] e [4];
    logic [15:0]        res [4];
    logic               in_fire;
    logic               out_fire;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7fff;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    assign in_fire  = ENABLE && readyi_q;
    // Beats after the first one ignore READYO when the block is kept together.
    assign out_fire = valid_q && (READYO || (TOGETHER && (ocnt_q != 2'd0)));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            e[i] = 18'(c_q[i]);
        end
    end

`ifdef H264INVDC_DEQUANT_EN
    logic [5:0]         qp_c;
    logic [2:0]         qp_rem_q, qp_rem_d;
    logic [3:0]         qp_div_q, qp_div_d;
    logic signed [31:0] ls;
    logic signed [31:0] scaled [4];
    logic [15:0]        scl_q [4];
    logic [15:0]        scl_d [4];

    assign qp_c = (QP > 6'd51) ? 6'd51 : QP;

    always_comb begin
        unique case (qp_rem_q)
            3'd0:    ls = 32'sd10;
            3'd1:    ls = 32'sd11;
            3'd2:    ls = 32'sd13;
            3'd3:    ls = 32'sd14;
            3'd4:    ls = 32'sd16;
            default: ls = 32'sd18;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            scaled[i] = ((32'(f_q[i]) * ls) <<< qp_div_q) >>> 5;
            res[i]    = scl_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res[i] = sat16(32'(f_q[i]));
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ocnt_d   = ocnt_q;
        readyi_d = readyi_q;
        valid_d  = valid_q;
        yyout_d  = yyout_q;
        c_d      = c_q;
        f_d      = f_q;
`ifdef H264INVDC_DEQUANT_EN
        qp_rem_d = qp_rem_q;
        qp_div_d = qp_div_q;
        scl_d    = scl_q;
`endif
        case (state_q)
            StLoad: begin
                readyi_d = 1'b1;
                if (in_fire) begin
                    c_d[cnt_q] = XXIN;
                    cnt_d      = cnt_q + 2'd1;
`ifdef H264INVDC_DEQUANT_EN
                    if (cnt_q == 2'd0) begin
                        qp_rem_d = 3'(qp_c % 6'd6);
                        qp_div_d = 4'(qp_c / 6'd6);
                    end
`endif
                    if (cnt_q == 2'd3) begin
                        state_d  = StCalc;
                        readyi_d = 1'b0;
                    end
                end
            end
            StCalc: begin
                f_d[0] = e[0] + e[1] + e[2] + e[3];
                f_d[1] = e[0] - e[1] + e[2] - e[3];
                f_d[2] = e[0] + e[1] - e[2] - e[3];
                f_d[3] = e[0] - e[1] - e[2] + e[3];
`ifdef H264INVDC_DEQUANT_EN
                state_d = StScale;
`else
                state_d = StOut;
`endif
            end
            StScale: begin
`ifdef H264INVDC_DEQUANT_EN
                for (int i = 0; i < 4; i++) begin
                    scl_d[i] = sat16(scaled[i]);
                end
`endif
                state_d = StOut;
            end
            StOut: begin
                // First cycle in OUT only primes the output register with beat 0.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    ocnt_d  = 2'd0;
                    yyout_d = res[0];
                end else if (out_fire) begin
                    if (ocnt_q == 2'd3) begin
                        valid_d  = 1'b0;
                        readyi_d = 1'b1;
                        state_d  = StLoad;
                    end else begin
                        ocnt_d  = ocnt_q + 2'd1;
                        yyout_d = res[ocnt_q + 2'd1];
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StLoad;
            cnt_q    <= 2'd0;
            ocnt_q   <= 2'd0;
            readyi_q <= 1'b0;
            valid_q  <= 1'b0;
            yyout_q  <= 16'd0;
            c_q      <= '{default: '0};
            f_q      <= '{default: '0};
`ifdef H264INVDC_DEQUANT_EN
            qp_rem_q <= 3'd0;
            qp_div_q <= 4'd0;
            scl_q    <= '{default: '0};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ocnt_q   <= ocnt_d;
            readyi_q <= readyi_d;
            valid_q  <= valid_d;
            yyout_q  <= yyout_d;
            c_q      <= c_d;
            f_q      <= f_d;
`ifdef H264INVDC_DEQUANT_EN
            qp_rem_q <= qp_rem_d;
            qp_div_q <= qp_div_d;
            scl_q    <= scl_d;
`endif
        end
    end

    assign READYI = readyi_q;
    assign VALID  = valid_q;
    assign YYOUT  = yyout_q;

endmodule

// File: tb/tb_h264invdc_transform.sv
// Directed bench for h264invdc_transform; a second instance runs with TOGETHER=1.
module tb_h264invdc_transform;

`ifdef H264INVDC_DEQUANT_EN
    localparam int Lat = 3;
    logic [5:0] qp = 6'd10;  // LS=16, shift 1: scaling is the identity
`else
    localparam int Lat = 2;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        readyo = 1'b1;
    logic [15:0] xxin   = 16'd0;
    logic        readyi, valid, readyi_t, valid_t;
    logic [15:0] yyout, yyout_t;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    h264invdc_transform #(.TOGETHER(1'b0)) dut (
        .CLK    (clk),
        .RESET  (rst_n),
        .READYI (readyi),
        .ENABLE (enable),
        .XXIN   (xxin),
`ifdef H264INVDC_DEQUANT_EN
        .QP     (qp),
`endif
        .VALID  (valid),
        .YYOUT  (yyout),
        .READYO (readyo)
    );

    h264invdc_transform #(.TOGETHER(1'b1)) dut_t (
        .CLK    (clk),
        .RESET  (rst_n),
        .READYI (readyi_t),
        .ENABLE (enable),
        .XXIN   (xxin),
`ifdef H264INVDC_DEQUANT_EN
        .QP     (qp),
`endif
        .VALID  (valid_t),
        .YYOUT  (yyout_t),
        .READYO (readyo)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (readyi !== 1'b1 && g < 30) begin
                step();
                g++;
            end
            if (readyi !== 1'b1) check("readyi_timeout", 32'(readyi), 1);
            enable = 1'b1;
            xxin   = 16'(v[i]);
            step();
        end
        enable = 1'b0;
    endtask

    // Called right after the 4th input edge; checks latency, data and stall holding.
    task automatic recv(input string tag, input int a, input int b, input int c, input int d,
                        input bit stall);
        int e[4];
        e = '{a, b, c, d};
        for (int k = 1; k < Lat; k++) begin
            step();
            check({tag, "_lat"}, 32'(valid), 0);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            check({tag, "_vld"}, 32'(valid), 1);
            check({tag, "_y"}, 32'($signed(yyout)), e[i]);
            check({tag, "_rdyi"}, 32'(readyi), 0);
            if (stall) begin
                readyo = 1'b0;
                repeat (3) begin
                    step();
                    check({tag, "_hold_y"}, 32'($signed(yyout)), e[i]);
                    check({tag, "_hold_vld"}, 32'(valid), 1);
                    check({tag, "_hold_rdyi"}, 32'(readyi), 0);
                end
                readyo = 1'b1;
            end
            step();
        end
        check({tag, "_end_vld"}, 32'(valid), 0);
        check({tag, "_end_rdyi"}, 32'(readyi), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        check("rst_readyi", 32'(readyi), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_yyout", 32'($signed(yyout)), 0);
        rst_n = 1'b1;
        check("rel_readyi", 32'(readyi), 0);
        step();
        check("rise_readyi", 32'(readyi), 1);

        send(4, 10, 2, 3, 1);
        recv("basic", 16, 10, 8, 6, 1'b0);
        send(4, -5, 0, 0, 0);
        recv("neg", -5, -5, -5, -5, 1'b0);
        send(4, 32767, 32767, 32767, 32767);
        recv("satp", 32767, 0, 0, 0, 1'b0);
        send(4, -32768, -32768, -32768, -32768);
        recv("satn", -32768, 0, 0, 0, 1'b0);
        send(4, 10, 2, 3, 1);
        recv("stall", 16, 10, 8, 6, 1'b1);

        // TOGETHER instance: fresh reset so both instances start aligned.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(4, 10, 2, 3, 1);
        repeat (Lat) step();
        check("tog_vld0", 32'(valid_t), 1);
        check("tog_y0", 32'($signed(yyout_t)), 16);
        step();
        check("tog_y1", 32'($signed(yyout_t)), 10);
        readyo = 1'b0;
        step();
        check("tog_vld2", 32'(valid_t), 1);
        check("tog_y2", 32'($signed(yyout_t)), 8);
        check("tog_ref_hold", 32'($signed(yyout)), 10);
        step();
        check("tog_y3", 32'($signed(yyout_t)), 6);
        step();
        check("tog_end_vld", 32'(valid_t), 0);
        check("tog_end_rdyi", 32'(readyi_t), 1);
        check("ref_stalled_vld", 32'(valid), 1);
        check("ref_stalled_y", 32'($signed(yyout)), 10);
        readyo = 1'b1;
        step();
        check("ref_y2", 32'($signed(yyout)), 8);
        step();
        check("ref_y3", 32'($signed(yyout)), 6);
        step();
        check("ref_end_vld", 32'(valid), 0);

        // Reset in the middle of loading a block.
        send(2, 7, 7, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_readyi", 32'(readyi), 0);
        check("mid_rst_valid", 32'(valid), 0);
        step();
        rst_n = 1'b1;
        check("mid_rel_readyi", 32'(readyi), 0);
        step();
        send(4, 1, 1, 1, 1);
        recv("post_rst", 4, 0, 0, 0, 1'b0);

        // Input beats offered while busy must be dropped.
        send(4, 1, 2, 3, 4);
        enable = 1'b1;
        xxin   = 16'd999;
        recv("busy", 10, -2, -4, 0, 1'b0);
        enable = 1'b0;
        send(4, 4, 0, 0, 0);
        recv("after_busy", 4, 4, 4, 4, 1'b0);

`ifdef H264INVDC_DEQUANT_EN
        qp = 6'd0;
        send(4, 10, 2, 3, 1);
        recv("dq_qp0", 5, 3, 2, 1, 1'b0);
        qp = 6'd12;
        send(4, 10, 2, 3, 1);
        recv("dq_qp12", 20, 12, 10, 7, 1'b0);
        qp = 6'd5;
        send(4, -1, 0, 0, 0);
        recv("dq_floor", -1, -1, -1, -1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/h264invdc_transform.md
Name: h264invdc_transform

Overview:
- Inverse 2x2 chroma DC Hadamard transform for the encoder reconstruction path.
- Receives the 4 DC coefficients of one chroma component from the dequantiser/quantiser side, serially in raster order (c00, c01, c10, c11).
- Emits the 4 reconstructed DC values, also in raster order, to the inverse 4x4 core transform.
- Serial ENABLE/READYI input and VALID/READYO output handshakes.

Parameters:
- TOGETHER, 0: 1 = once the first output beat is accepted, the remaining 3 beats issue on consecutive cycles ignoring READYO (block kept together).

Ports:
- CLK  in  1  fast clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READYI  out  1  block can accept an input beat.
- ENABLE  in  1  input beat present; accepted on a rising edge when ENABLE=1 and READYI=1.
- XXIN  in  16  signed input coefficient.
- VALID  out  1  YYOUT holds an output beat.
- YYOUT  out  16  signed output value.
- READYO  in  1  downstream accepts YYOUT this cycle.

Behaviour:
- Reset: one clock; RESET is asynchronous and active-low. Reset values:
  - READYI=0, VALID=0, YYOUT=0.
  - state=LOAD, beat counter=0, coefficient registers cleared.
  - READYI rises on the first clock edge after RESET deasserts.
- LOAD state:
  - READYI=1.
  - Each accepted beat stores XXIN into c[cnt]; cnt increments modulo 4.
  - When the 4th beat is accepted (cnt 3 to 0), go to CALC; READYI drops the next cycle.
- CALC state: one cycle, READYI=0. Registers (18-bit signed, sign-extended inputs):
  - f00 = c00+c01+c10+c11
  - f01 = c00-c01+c10-c11
  - f10 = c00+c01-c10-c11
  - f11 = c00-c01-c10+c11
  - Then go to OUT.
- OUT state:
  - VALID=1 and YYOUT = sat16(f[ocnt]) for ocnt 0..3.
  - A beat completes on an edge with READYO=1; ocnt then increments.
  - While READYO=0, VALID and YYOUT hold stable (no drop, no change).
  - After beat 3 completes, VALID=0 and state=LOAD, READYI=1 the same cycle. There is no overlap between input and output of different blocks.
- TOGETHER=1: beat 0 waits for READYO; beats 1..3 follow on consecutive cycles regardless of READYO.
- Latency: 4th input accepted at edge N → VALID=1 with f00 after edge N+2. Minimum throughput is one block per 10 cycles.
- Saturation (sat16): clip to [-32768, 32767].
- ENABLE while READYI=0: ignored, data is dropped, and no state changes.
- Simultaneous events: none possible between input and output, by construction of the states.
- RESET low mid-block (any state): immediate return to reset values. Partial input and pending output are discarded, with no residual beats after release.

Optional Feature:
- Macro H264INVDC_DEQUANT_EN.
- Defined:
  - Adds input port QP [5:0], sampled with the first beat (c00) of each block and held for that block.
  - Each output = sat16(((f * LS[QP%6]) << (QP/6)) >>> 5), with LS = {10, 11, 13, 14, 16, 18}.
  - The shift right is arithmetic (floor).
  - Intermediate width is at least 32-bit signed.
  - The scaling is registered in the CALC path; latency grows to N+3.
  - QP above 51 is clipped to 51.
- Undefined: no QP port; outputs are raw sat16(f); latency N+2.

Test Plan:
- Inputs 10, 2, 3, 1, READYO=1 → YYOUT 16, 10, 8, 6 with VALID high on 4 consecutive cycles; first VALID 2 cycles after the last input edge.
- Inputs -5, 0, 0, 0 → -5, -5, -5, -5. Inputs 32767 ×4 → 32767, 0, 0, 0 (saturated). Inputs -32768 ×4 → -32768, 0, 0, 0.
- Backpressure: inputs 10, 2, 3, 1 with READYO low for 3 cycles at each beat → YYOUT held constant while stalled, sequence still 16, 10, 8, 6, READYI=0 throughout OUT. With TOGETHER=1 and READYO dropped after beat 0 → beats 1..3 still issue on consecutive cycles.
- Reset mid-block: accept 2 beats, pull RESET low 1 cycle → READYI=0 and VALID=0 during reset. Then a full block 1, 1, 1, 1 → 4, 0, 0, 0 with no stale data.
- ENABLE asserted during CALC/OUT with XXIN=999 → ignored; the next block 4, 0, 0, 0 → 4, 4, 4, 4.
- H264INVDC_DEQUANT_EN:
  - QP=0, inputs 10, 2, 3, 1 → 5, 3, 2, 1.
  - QP=12 → 20, 12, 10, 7.
  - QP=5, inputs -1, 0, 0, 0 → -1, -1, -1, -1 (floor).
